rd_ws_responder: RTL
====================

# rd_ws_responder

Wait-state read responder that sits directly downstream of the go/ws read-control FSM. It consumes that FSM's registered `rd` and `ds` strobes, answers each READ/DLY attempt with a registered `ws` decision, and returns a word from a small local memory. It stretches every transaction by a programmable number of wait attempts and flags protocol violations.

## Interface
- `DW`, 8, data width
- `AW`, 4, address width; memory depth is 2**AW
- `WW`, 3, width of the wait-count configuration

- `clk`  in  1  clock; all logic on the rising edge
- `rstn`  in  1  asynchronous active-low reset
- `rd`  in  1  read strobe from the controller; high during its READ and DLY cycles
- `ds`  in  1  done strobe from the controller; one-cycle pulse in its DONE cycle
- `addr`  in  AW  read address; sampled at transaction start
- `wait_cfg`  in  WW  number of ws=1 attempts; sampled at transaction start
- `we`  in  1  memory write enable
- `waddr`  in  AW  write address
- `wdata`  in  DW  write data
- `ws`  out  1  registered wait-state answer; valid in the controller's DLY cycle
- `rdata`  out  DW  registered read data; held until the next capture
- `rvalid`  out  1  one-cycle pulse the cycle after an accepted `ds`
- `err`  out  1  sticky protocol-error flag

## Operation
- Memory: 2**AW x DW registers, no reset. A write with `we=1` lands at the edge.
- States: R_IDLE, R_ACT (carries `phase`: 0 = READ cycle expected, 1 = DLY cycle expected), R_CMPL.
- R_IDLE, `rd=1`:
  - latch `addr`
  - `ws <= (wait_cfg != 0)`
  - `cnt <= (wait_cfg == 0) ? 0 : wait_cfg - 1`
  - go to R_ACT with phase=1
- R_ACT, phase=1 (DLY cycle), `rd=1`:
  - if `ws=0`: `rdata <= mem[latched addr]` (old value on a same-cycle write); go to R_CMPL
  - else: phase <= 0
- R_ACT, phase=0 (READ cycle), `rd=1`:
  - `ws <= (cnt != 0)`
  - `cnt` decrements if nonzero
  - phase <= 1
- R_CMPL, `ds=1`: `rvalid <= 1`; go to R_IDLE.
- Errors set `err` (sticky until reset); all are ignored without `RDWS_ERR_EN`:
  - `rd=0` in R_ACT: abort; go to R_IDLE; `ws <= 0`
  - `ds=1` in R_IDLE or R_ACT
  - `rd=1` in R_CMPL: stay in R_CMPL
- `ws` is forced to 0 in R_IDLE and R_CMPL.
- A transaction makes exactly `wait_cfg + 1` attempts, with `rd` high for `2*(wait_cfg+1)` consecutive cycles.

## Timing
- Reset values: `ws=0`, `rdata=0`, `rvalid=0`, `err=0`, state R_IDLE, `phase=0`, `cnt=0`.
- Reset mid-transaction returns all of the above immediately; memory contents are unchanged.
- `wait_cfg=0`, with cycle 0 as the first `rd=1`:
  - cycle 1: `ws=0`
  - cycle 2: `rdata` valid, controller `ds=1`
  - cycle 3: `rvalid=1`
- `wait_cfg=W`: `ws=1` in DLY cycles 1, 3, …, 2W-1; `ws=0` in cycle 2W+1; `rvalid` in cycle 2W+3.
- Back-to-back transactions: the controller's earliest next `rd` is 2 cycles after `ds`. The responder is already in R_IDLE, so no bubble is required.
- `wait_cfg` changes mid-transaction have no effect.

## Configuration
- `RDWS_ERR_EN` defined:
  - error detection as above
  - an `rd=0` abort in R_ACT sets `err`
- `RDWS_ERR_EN` undefined:
  - `err` is tied to 0
  - an `rd=0` in R_ACT still returns to R_IDLE silently
  - `ds` outside R_CMPL is ignored
  - `rd` in R_CMPL is ignored

## Test plan
- Write mem[3]=8'hA5; `addr=3`, `wait_cfg=0`, controller with `go=1` -> `ws=0` in DLY; `rdata=8'hA5` in DONE; `rvalid` one cycle later; `err=0`.
- `wait_cfg=3`, mem[7]=8'h3C -> controller sees `ws=1,1,1,0` across 4 DLY cycles; `rd` high 8 cycles; `rdata=8'h3C`; one `rvalid` pulse.
- Two back-to-back reads (`go` held), mem[1]=8'h11, mem[2]=8'h22, `wait_cfg=1` -> `rvalid` pulses 6 cycles apart; `rdata` 8'h11 then 8'h22.
- Write mem[5]=8'hFF in the same cycle as the final-DLY capture of mem[5] (old 8'h00) -> `rdata=8'h00`; the next read returns 8'hFF.
- With `RDWS_ERR_EN`: pulse `ds` in R_IDLE -> `err=1` and stays 1 through a following good read. Drop `rd` in R_ACT -> `err=1`, `ws=0`, state R_IDLE.
- Assert `rstn=0` during a `wait_cfg=7` wait -> `ws`, `rvalid`, `err`, `rdata` all 0 next cycle; the next read completes normally.

Source files
------------

// File: rtl/rd_ws_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rd_ws_responder: wait-state read responder for the go/ws read controller. |
// | Answers each READ/DLY attempt with a registered ws and returns mem data.  |
// | Optional feature macro: RDWS_ERR_EN (sticky protocol-error detection).    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module rd_ws_responder #(
  parameter int DW = 8,
  parameter int AW = 4,
  parameter int WW = 3
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          rd,
  input  logic          ds,
  input  logic [AW-1:0] addr,
  input  logic [WW-1:0] wait_cfg,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  output logic          ws,
  output logic [DW-1:0] rdata,
  output logic          rvalid,
  output logic          err
);

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ACT  = 2'd1,
    R_CMPL = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic          phase, phase_nx;
  logic [WW-1:0] cnt, cnt_nx;
  logic [AW-1:0] lat_addr, lat_addr_nx;
  logic          ws_nx;
  logic [DW-1:0] rdata_nx;
  logic          rvalid_nx;

  logic [DW-1:0] mem [2**AW];

  // Storage is deliberately not reset so contents survive a mid-transaction reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

`ifdef RDWS_ERR_EN
  logic err_q, err_nx;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= R_IDLE;
      phase    <= 1'b0;
      cnt      <= '0;
      lat_addr <= '0;
      ws       <= 1'b0;
      rdata    <= '0;
      rvalid   <= 1'b0;
`ifdef RDWS_ERR_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state    <= state_nx;
      phase    <= phase_nx;
      cnt      <= cnt_nx;
      lat_addr <= lat_addr_nx;
      ws       <= ws_nx;
      rdata    <= rdata_nx;
      rvalid   <= rvalid_nx;
`ifdef RDWS_ERR_EN
      err_q    <= err_nx;
`endif
    end
  end

  always_comb begin
    state_nx    = state;
    phase_nx    = phase;
    cnt_nx      = cnt;
    lat_addr_nx = lat_addr;
    ws_nx       = ws;
    rdata_nx    = rdata;
    rvalid_nx   = 1'b0;
`ifdef RDWS_ERR_EN
    err_nx      = err_q;
`endif
    case (state)
      R_IDLE: begin
        ws_nx = 1'b0;
`ifdef RDWS_ERR_EN
        if (ds) err_nx = 1'b1;
`endif
        if (rd) begin
          lat_addr_nx = addr;
          ws_nx       = (wait_cfg != '0);
          cnt_nx      = (wait_cfg == '0) ? '0 : wait_cfg - WW'(1);
          phase_nx    = 1'b1;
          state_nx    = R_ACT;
        end
      end
      R_ACT: begin
`ifdef RDWS_ERR_EN
        if (ds) err_nx = 1'b1;
`endif
        if (!rd) begin
          // Controller abandoned the transaction: drop back quietly.
          state_nx = R_IDLE;
          phase_nx = 1'b0;
          ws_nx    = 1'b0;
`ifdef RDWS_ERR_EN
          err_nx   = 1'b1;
`endif
        end else if (phase) begin
          if (!ws) begin
            rdata_nx = mem[lat_addr];
            phase_nx = 1'b0;
            state_nx = R_CMPL;
          end else begin
            phase_nx = 1'b0;
          end
        end else begin
          ws_nx    = (cnt != '0);
          cnt_nx   = (cnt != '0) ? cnt - WW'(1) : cnt;
          phase_nx = 1'b1;
        end
      end
      R_CMPL: begin
        ws_nx = 1'b0;
`ifdef RDWS_ERR_EN
        if (rd) err_nx = 1'b1;
`endif
        if (ds) begin
          rvalid_nx = 1'b1;
          state_nx  = R_IDLE;
        end
      end
      default: begin
        state_nx = R_IDLE;
        phase_nx = 1'b0;
        ws_nx    = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire
